// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch stage with req/ack instruction memory port, prefetch FIFO and decode redirect
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jFlag,
    input  logic [31:0] PC_in,
    output logic [31:0] instr,
    output logic [31:0] PC_out,
    output logic        done_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_addr [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          redirect, push, pop, issue;
    logic          pc_in_unused;

    // jFlag only counts on the cycle a fresh instruction is on the decode interface
    assign redirect     = jFlag & done_out;
    assign push         = state == REQ && imem_ack && !redirect;
    assign pop          = count != '0 && !stall && !redirect;
    assign issue        = state == IDLE && !redirect && count < DEPTH;
    assign pc_in_unused = ^PC_in[1:0];

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // next state: one outstanding request; a redirect mid-request waits out the ack in DISCARD
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = issue ? REQ : IDLE;
            REQ:     state_next = imem_ack ? IDLE : (redirect ? DISCARD : REQ);
            DISCARD: state_next = imem_ack ? IDLE : DISCARD;
            default: state_next = IDLE;
        endcase
    end

    // memory port, fetch PC, FIFO pointers and decode-side presentation registers
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            instr     <= '0;
            PC_out    <= '0;
            done_out  <= 1'b0;
        end else begin
            imem_req <= state_next != IDLE;
            if (issue) imem_addr <= fetch_pc;
            if (redirect)  fetch_pc <= {PC_in[31:2], 2'b00};
            else if (push) fetch_pc <= fetch_pc + 32'd4;
            done_out <= pop;
            if (pop) begin
                instr  <= fifo_data[rd_ptr];
                PC_out <= fifo_addr[rd_ptr] + 32'd4;
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO storage keeps each word with the address it was fetched from
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_addr[wr_ptr] <= imem_addr;
        end
    end
endmodule
